// File: rtl/load_controller.sv
// rtl/load_controller.sv - load unit: request FSM, alignment/funct3 checks, timeout, byte/half extraction
module module_extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  input  logic             uext,
  output logic [OUT_W-1:0] dout
);
  assign dout = {{(OUT_W-IN_W){uext ? 1'b0 : din[IN_W-1]}}, din};
endmodule

module load_controller #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [1:0]      resp_err,
  output logic            busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] rdata_q;
  logic [1:0]      err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            illegal, misaligned;
  logic [XLEN-1:0] byte_ext, half_ext;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    illegal = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = (req_addr[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Timeout is checked after the acknowledge, so an ack on the last allowed cycle wins.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (illegal) begin
            err_d   = 2'b10;
            state_d = ERR;
          end else if (misaligned) begin
            err_d   = 2'b01;
            state_d = ERR;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = RESP;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          err_d   = 2'b11;
          state_d = ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      funct3_q <= 3'b000;
      rdata_q  <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
      end
      if (state_q == REQ && mem_ack) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign byte_sel = rdata_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = rdata_q[{addr_q[1], 4'b0000} +: 16];

  module_extend #(8, XLEN) u_ext_byte (
    .din  (byte_sel),
    .uext (funct3_q[2]),
    .dout (byte_ext)
  );

  module_extend #(16, XLEN) u_ext_half (
    .din  (half_sel),
    .uext (funct3_q[2]),
    .dout (half_ext)
  );

  always_comb begin
    req_ready  = (state_q == IDLE);
    busy       = (state_q != IDLE);
    mem_req    = (state_q == REQ);
    mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    resp_valid = (state_q == RESP) || (state_q == ERR);
    resp_err   = 2'b00;
    resp_data  = '0;
    if (state_q == ERR) begin
      resp_err = err_q;
    end
    if (state_q == RESP) begin
      case (funct3_q[1:0])
        2'b00:   resp_data = byte_ext;
        2'b01:   resp_data = half_ext;
        default: resp_data = rdata_q;
      endcase
    end
  end
endmodule

// File: tb/tb_load_controller.sv
// tb/tb_load_controller.sv - directed scoreboard bench for load_controller
module tb_load_controller;
  localparam int XLEN = 32;
  localparam int TO   = 15;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [XLEN-1:0] req_addr = '0;
  logic [2:0]      req_funct3 = 3'b000;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic [1:0]      resp_err;
  logic            busy;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          mreq;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  load_controller #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_funct3 (req_funct3),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // ack_at: REQ cycle (1-based) on which mem_ack is driven; 0 means never.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                     input int ack_at, input logic [31:0] rdata,
                     input logic [31:0] exp_data, input logic [1:0] exp_err,
                     input int exp_lat, input int exp_mreq);
    exp_t e;
    exp_t x;
    int mreq;
    bit done;
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr = addr;
    req_funct3 = f3;
    e.data = exp_data;
    e.err = exp_err;
    e.lat = exp_lat;
    e.mreq = exp_mreq;
    sb.push_back(e);
    mreq = 0;
    done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_ack = 1'b0;
      if (resp_valid) begin
        x = sb.pop_front();
        chk({tag, ".data"}, resp_data, x.data);
        chk({tag, ".err"}, resp_err, x.err);
        chk({tag, ".latency"}, k, x.lat);
        chk({tag, ".mem_req_cycles"}, mreq, x.mreq);
        done = 1;
      end else begin
        if (mem_req) mreq++;
        if (k == 1) begin
          chk({tag, ".busy"}, busy, 1);
          chk({tag, ".ready_busy"}, req_ready, 0);
          if (mem_req) chk({tag, ".mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
          req_valid = 1'b1;
          req_addr = 32'h0000_0001;
          req_funct3 = 3'b011;
        end
        if (mem_req && k == ack_at) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end
      end
    end
    chk({tag, ".resp_seen"}, done, 1);
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, ".pulse_end"}, resp_valid, 0);
    chk({tag, ".idle"}, req_ready, 1);
  endtask

  initial begin
    #12;
    chk("reset.mem_req", mem_req, 0);
    chk("reset.resp_valid", resp_valid, 0);
    chk("reset.resp_err", resp_err, 0);
    chk("reset.resp_data", resp_data, 0);
    chk("reset.mem_addr", mem_addr, 0);
    chk("reset.busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset.ready", req_ready, 1);

    txn("lb_103",   32'h103, 3'b000, 2,  32'h80FF_1234, 32'hFFFF_FF80, 2'b00, 3, 2);
    txn("lb_100",   32'h100, 3'b000, 1,  32'h80FF_1234, 32'h0000_0034, 2'b00, 2, 1);
    txn("lhu_102",  32'h102, 3'b101, 1,  32'h8001_0000, 32'h0000_8001, 2'b00, 2, 1);
    txn("lh_102",   32'h102, 3'b001, 1,  32'h8001_0000, 32'hFFFF_8001, 2'b00, 2, 1);
    txn("lh_100",   32'h100, 3'b001, 2,  32'h1234_F00D, 32'hFFFF_F00D, 2'b00, 3, 2);
    txn("lw_200",   32'h200, 3'b010, 3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 4, 3);
    txn("lw_mis",   32'h101, 3'b010, 0,  32'h0,         32'h0,         2'b01, 1, 0);
    txn("lh_mis",   32'h103, 3'b001, 0,  32'h0,         32'h0,         2'b01, 1, 0);
    txn("f3_011",   32'h101, 3'b011, 0,  32'h0,         32'h0,         2'b10, 1, 0);
    txn("f3_111",   32'h000, 3'b111, 0,  32'h0,         32'h0,         2'b10, 1, 0);
    txn("lw_tmo",   32'h200, 3'b010, 0,  32'h0,         32'h0,         2'b11, TO + 1, TO);
    txn("lw_last",  32'h204, 3'b010, TO, 32'h5A5A_A5A5, 32'h5A5A_A5A5, 2'b00, TO + 1, TO);

    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h300;
    req_funct3 = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.mem_req_on", mem_req, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid.mem_req_off", mem_req, 0);
    chk("rst_mid.resp_valid", resp_valid, 0);
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.mem_addr", mem_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      chk("late_ack.resp_valid", resp_valid, 0);
      chk("late_ack.busy", busy, 0);
    end

    txn("lbu_0", 32'h000, 3'b100, 1, 32'h0000_00AB, 32'h0000_00AB, 2'b00, 2, 1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/load_controller.md
LOAD_CONTROLLER -- requirements
Module: load_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset; clock and reset ports are listed first below.
REQ-002 Parameter: XLEN, 32, data and address width.
REQ-003 Parameter: TIMEOUT_CYCLES, 15, maximum cycles mem_req is held without mem_ack.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  core load request.
REQ-007 req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-008 req_addr  in  XLEN  byte address of load.
REQ-009 req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal.
REQ-010 mem_req  out  1  memory read request, held until mem_ack or timeout.
REQ-011 mem_addr  out  XLEN  word-aligned address {addr[31:2],2'b00}.
REQ-012 mem_ack  in  1  memory read data valid this cycle.
REQ-013 mem_rdata  in  XLEN  memory read word.
REQ-014 resp_valid  out  1  one-cycle pulse, response available.
REQ-015 resp_data  out  XLEN  extracted and extended load result.
REQ-016 resp_err  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, RESP, ERR.
REQ-019 On acceptance, addr and funct3 SHALL be registered; next state REQ if legal and aligned, otherwise ERR.
REQ-020 Illegal funct3 SHALL take priority over misalignment (err 10 before 01).
REQ-021 Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=00; byte loads never misaligned.
REQ-022 In REQ, mem_req=1 and mem_addr constant; on mem_ack, mem_rdata SHALL be registered and state -> RESP.
REQ-023 In REQ, a counter SHALL increment each cycle without mem_ack; when it equals TIMEOUT_CYCLES, state -> ERR with err 11, mem_req deasserted.
REQ-024 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win (normal RESP).
REQ-025 mem_ack outside REQ SHALL be ignored.
REQ-026 Byte select: rdata[8*addr[1:0] +: 8]; halfword select: rdata[16*addr[1] +: 16]; word: rdata.
REQ-027 Extension SHALL use module_extend #(8,XLEN) and #(16,XLEN) instances with uext = funct3[2].
REQ-028 RESP: resp_valid=1, resp_err=00, resp_data valid for exactly one cycle; then IDLE.
REQ-029 ERR: resp_valid=1, resp_err set, resp_data=0 for one cycle; then IDLE; mem_req never asserted for 01/10.
REQ-030 Latency: accept at cycle N, mem_req at N+1, mem_ack at N+k gives resp_valid at N+k+1; error response at N+1.
REQ-031 No new request SHALL be accepted until IDLE; req_valid while busy SHALL be ignored.

Reset
REQ-032 reset_n low SHALL immediately force IDLE, mem_req=0, resp_valid=0, resp_err=00, resp_data=0, mem_addr=0, busy=0, req_ready=1 after release, counter=0.
REQ-033 Reset mid-transaction SHALL abort without a response; a late mem_ack after release SHALL be ignored.

Verification
REQ-034 LB addr 0x103, rdata 0x80FF_1234, ack after 2 cycles -> resp_data 0xFFFF_FF80, err 00, resp_valid 3 cycles after accept.
REQ-035 LHU addr 0x102, rdata 0x8001_0000, ack immediately -> resp_data 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-036 LW addr 0x101 -> err 01, resp_data 0, mem_req never high; funct3 011 addr 0x101 -> err 10.
REQ-037 LW addr 0x200, no ack -> mem_req high exactly TIMEOUT_CYCLES cycles, then err 11; ack on final cycle -> err 00 with data.
REQ-038 reset_n pulsed low while in REQ -> mem_req drops asynchronously, no resp_valid, subsequent LBU addr 0x0 rdata 0xAB -> 0x0000_00AB.
